mem_tester: RTL and testbench

Bus initiator for the native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata) that drives the BRAM controller and any other responder on that bus. On a start pulse it writes a deterministic pattern to NUM_WORDS consecutive words from BASE_ADDR, reads them back, compares each word and reports pass/fail, error count, first failing address and responder timeout. It serves as a board-level self-test and as the bus master for bring-up, ahead of the CPU.

---
 rtl/mem_tester_pkg.sv | 23 ++
 rtl/mem_tester.sv | 217 +++++++++++++++++++++
 tb/tb_mem_tester.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_tester_pkg.sv
// Shared types and helpers for the memory self-test bus initiator.
// Holds the FSM state encoding, strobe constants and the test pattern.
package mem_tester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_GAP = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_GAP = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    localparam logic [3:0] WSTRB_WORD = 4'b1111;
    localparam logic [3:0] WSTRB_READ = 4'b0000;

    // Index in the upper half, its complement in the lower half: every word is unique
    // and every data bit toggles across the address range.
    function automatic logic [31:0] pattern(input logic [15:0] idx);
        return {idx, ~idx};
    endfunction

endpackage

// File: rtl/mem_tester.sv
// Memory self-test initiator: writes a pattern to NUM_WORDS words, reads it back,
// and reports pass/fail, error count, first failing address and responder timeout.
module mem_tester
    import mem_tester_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_WORDS = 256,
    parameter int          TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [31:0] first_err_addr,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam int              TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [15:0]     LAST_IDX = 16'(NUM_WORDS - 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

    function automatic logic [31:0] addr_of(input logic [15:0] idx);
        return BASE_ADDR + {14'd0, idx, 2'b00};
    endfunction

    state_t           r_state, w_state;
    logic [15:0]      r_idx, w_idx;
    logic [TO_W-1:0]  r_to_cnt, w_to_cnt;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             r_pass, w_pass;
    logic             r_timeout, w_timeout;
    logic [15:0]      r_err_count, w_err_count;
    logic [31:0]      r_first_err_addr, w_first_err_addr;
    logic             r_mem_valid, w_mem_valid;
    logic [31:0]      r_mem_addr, w_mem_addr;
    logic [31:0]      r_mem_wdata, w_mem_wdata;
    logic [3:0]       r_mem_wstrb, w_mem_wstrb;

    // Next-state and next-output computation; every output is the registered copy of these.
    always_comb begin
        w_state          = r_state;
        w_idx            = r_idx;
        w_to_cnt         = r_to_cnt;
        w_busy           = r_busy;
        w_done           = r_done;
        w_pass           = r_pass;
        w_timeout        = r_timeout;
        w_err_count      = r_err_count;
        w_first_err_addr = r_first_err_addr;
        w_mem_valid      = r_mem_valid;
        w_mem_addr       = r_mem_addr;
        w_mem_wdata      = r_mem_wdata;
        w_mem_wstrb      = r_mem_wstrb;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_done           = 1'b0;
                    w_pass           = 1'b0;
                    w_timeout        = 1'b0;
                    w_err_count      = 16'd0;
                    w_first_err_addr = 32'd0;
                    w_idx            = 16'd0;
                    w_to_cnt         = '0;
                    w_busy           = 1'b1;
                    w_mem_valid      = 1'b1;
                    w_mem_addr       = addr_of(16'd0);
                    w_mem_wdata      = pattern(16'd0);
                    w_mem_wstrb      = WSTRB_WORD;
                    w_state          = ST_WR_REQ;
                end else begin
                    w_state = ST_IDLE;
                end
            end

            ST_WR_REQ: begin
                if (mem_ready) begin
                    w_mem_valid = 1'b0;
                    w_to_cnt    = '0;
                    if (r_idx == LAST_IDX) begin
                        w_idx   = 16'd0;
                        w_state = ST_RD_GAP;
                    end else begin
                        w_idx   = r_idx + 16'd1;
                        w_state = ST_WR_GAP;
                    end
                end else if (r_to_cnt == TO_LIMIT) begin
                    w_timeout   = 1'b1;
                    w_mem_valid = 1'b0;
                    w_to_cnt    = '0;
                    w_state     = ST_FINISH;
                end else begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end

            ST_WR_GAP: begin
                w_mem_valid = 1'b1;
                w_mem_addr  = addr_of(r_idx);
                w_mem_wdata = pattern(r_idx);
                w_mem_wstrb = WSTRB_WORD;
                w_state     = ST_WR_REQ;
            end

            ST_RD_GAP: begin
                w_mem_valid = 1'b1;
                w_mem_addr  = addr_of(r_idx);
                w_mem_wdata = 32'd0;
                w_mem_wstrb = WSTRB_READ;
                w_state     = ST_RD_REQ;
            end

            ST_RD_REQ: begin
                if (mem_ready) begin
                    w_mem_valid = 1'b0;
                    w_to_cnt    = '0;
                    // The first-address latch keys off the pre-increment count.
                    if (mem_rdata != pattern(r_idx)) begin
                        if (r_err_count != 16'hFFFF) begin
                            w_err_count = r_err_count + 16'd1;
                        end else begin
                            w_err_count = r_err_count;
                        end
                        if (r_err_count == 16'd0) begin
                            w_first_err_addr = r_mem_addr;
                        end else begin
                            w_first_err_addr = r_first_err_addr;
                        end
                    end else begin
                        w_err_count = r_err_count;
                    end
                    if (r_idx == LAST_IDX) begin
                        w_state = ST_FINISH;
                    end else begin
                        w_idx   = r_idx + 16'd1;
                        w_state = ST_RD_GAP;
                    end
                end else if (r_to_cnt == TO_LIMIT) begin
                    w_timeout   = 1'b1;
                    w_mem_valid = 1'b0;
                    w_to_cnt    = '0;
                    w_state     = ST_FINISH;
                end else begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end

            ST_FINISH: begin
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_pass  = (r_err_count == 16'd0) && !r_timeout;
                w_state = ST_IDLE;
            end

            default: begin
                w_busy      = 1'b0;
                w_mem_valid = 1'b0;
                w_state     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_idx            <= 16'd0;
            r_to_cnt         <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_timeout        <= 1'b0;
            r_err_count      <= 16'd0;
            r_first_err_addr <= 32'd0;
            r_mem_valid      <= 1'b0;
            r_mem_addr       <= 32'd0;
            r_mem_wdata      <= 32'd0;
            r_mem_wstrb      <= 4'd0;
        end else begin
            r_state          <= w_state;
            r_idx            <= w_idx;
            r_to_cnt         <= w_to_cnt;
            r_busy           <= w_busy;
            r_done           <= w_done;
            r_pass           <= w_pass;
            r_timeout        <= w_timeout;
            r_err_count      <= w_err_count;
            r_first_err_addr <= w_first_err_addr;
            r_mem_valid      <= w_mem_valid;
            r_mem_addr       <= w_mem_addr;
            r_mem_wdata      <= w_mem_wdata;
            r_mem_wstrb      <= w_mem_wstrb;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign timeout        = r_timeout;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;
    assign mem_valid      = r_mem_valid;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign mem_wstrb      = r_mem_wstrb;

endmodule

// File: tb/tb_mem_tester.sv
// Self-checking bench for mem_tester with NUM_WORDS=4 against a BRAM-like responder
// (3 valid cycles per word) that can corrupt reads or never answer.
module tb_mem_tester;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    mem_tester #(
        .BASE_ADDR(32'h0000_0000),
        .NUM_WORDS(4),
        .TIMEOUT  (15)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rdata     (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    typedef struct {
        int          mode;
        logic        exp_pass;
        logic [15:0] exp_err;
        logic [31:0] exp_first;
        logic        exp_to;
        int          exp_cycles;
        int          exp_vhigh;
        int          exp_txns;
    } scen_t;

    int          total;
    int          bad;
    int          mode;
    txn_t        obs_q[$];
    txn_t        exp_tbl[8];
    scen_t       sc[4];
    logic [31:0] rmem[16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Responder: ready after the third valid cycle; mode 1 flips bit 0 on reads of 0x8/0xC,
    // mode 2 never answers.
    initial begin
        int rcnt;
        rcnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        for (int k = 0; k < 16; k++) rmem[k] = 32'd0;
        forever begin
            @(negedge clk);
            if (!reset_n || !mem_valid || mem_ready) begin
                rcnt = 0;
                mem_ready = 1'b0;
            end else begin
                rcnt++;
                if (rcnt == 3 && mode != 2) begin
                    mem_ready = 1'b1;
                    obs_q.push_back('{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb});
                    if (mem_wstrb == 4'hF) rmem[mem_addr[5:2]] = mem_wdata;
                    mem_rdata = rmem[mem_addr[5:2]];
                    if (mode == 1 && (mem_addr == 32'h8 || mem_addr == 32'hC))
                        mem_rdata = mem_rdata ^ 32'h0000_0001;
                end
            end
        end
    end

    // Bus protocol monitor: stability under valid, drop after handshake, single-cycle gaps.
    initial begin
        logic        p_valid, p_ready;
        logic [31:0] p_addr, p_wdata;
        logic [3:0]  p_wstrb;
        int          gap;
        p_valid = 1'b0; p_ready = 1'b0; p_addr = 32'd0; p_wdata = 32'd0; p_wstrb = 4'd0; gap = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                p_valid = 1'b0; p_ready = 1'b0; gap = 0;
            end else begin
                if (p_valid && !p_ready && mem_valid) begin
                    chk32("stable_addr", mem_addr, p_addr);
                    chk32("stable_wdata", mem_wdata, p_wdata);
                    chk32("stable_wstrb", 32'(mem_wstrb), 32'(p_wstrb));
                end
                if (p_valid && p_ready) chk1("valid_drop_after_ready", mem_valid, 1'b0);
                if (busy && !mem_valid) gap++;
                else gap = 0;
                if (gap > 1) chk32("gap_len", 32'(gap), 32'd1);
                p_valid = mem_valid; p_ready = mem_ready;
                p_addr = mem_addr; p_wdata = mem_wdata; p_wstrb = mem_wstrb;
            end
        end
    end

    initial begin
        int n, vh;
        total = 0; bad = 0; mode = 0;
        reset_n = 1'b0; start = 1'b0;

        exp_tbl[0] = '{addr: 32'h0, wdata: 32'h0000FFFF, wstrb: 4'hF};
        exp_tbl[1] = '{addr: 32'h4, wdata: 32'h0001FFFE, wstrb: 4'hF};
        exp_tbl[2] = '{addr: 32'h8, wdata: 32'h0002FFFD, wstrb: 4'hF};
        exp_tbl[3] = '{addr: 32'hC, wdata: 32'h0003FFFC, wstrb: 4'hF};
        exp_tbl[4] = '{addr: 32'h0, wdata: 32'h0, wstrb: 4'h0};
        exp_tbl[5] = '{addr: 32'h4, wdata: 32'h0, wstrb: 4'h0};
        exp_tbl[6] = '{addr: 32'h8, wdata: 32'h0, wstrb: 4'h0};
        exp_tbl[7] = '{addr: 32'hC, wdata: 32'h0, wstrb: 4'h0};

        sc[0] = '{mode: 0, exp_pass: 1'b1, exp_err: 16'd0, exp_first: 32'h0, exp_to: 1'b0, exp_cycles: 32, exp_vhigh: 24, exp_txns: 8};
        sc[1] = '{mode: 1, exp_pass: 1'b0, exp_err: 16'd2, exp_first: 32'h8, exp_to: 1'b0, exp_cycles: 32, exp_vhigh: 24, exp_txns: 8};
        sc[2] = '{mode: 2, exp_pass: 1'b0, exp_err: 16'd0, exp_first: 32'h0, exp_to: 1'b1, exp_cycles: 16, exp_vhigh: 15, exp_txns: 0};
        sc[3] = '{mode: 0, exp_pass: 1'b1, exp_err: 16'd0, exp_first: 32'h0, exp_to: 1'b0, exp_cycles: 32, exp_vhigh: 24, exp_txns: 8};

        repeat (3) @(negedge clk);
        chk1("rst_valid", mem_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_pass", pass, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk32("rst_err", 32'(err_count), 32'd0);
        chk32("rst_first", first_err_addr, 32'd0);
        chk32("rst_addr", mem_addr, 32'd0);
        chk32("rst_wdata", mem_wdata, 32'd0);
        chk32("rst_wstrb", 32'(mem_wstrb), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int s = 0; s < 4; s++) begin
            mode = sc[s].mode;
            obs_q.delete();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk1("start_busy", busy, 1'b1);
            chk1("start_valid", mem_valid, 1'b1);
            chk32("start_addr", mem_addr, 32'h0);
            chk32("start_wdata", mem_wdata, 32'h0000FFFF);
            chk32("start_wstrb", 32'(mem_wstrb), 32'hF);
            chk1("start_clr_done", done, 1'b0);
            chk1("start_clr_pass", pass, 1'b0);
            chk1("start_clr_to", timeout, 1'b0);
            chk32("start_clr_err", 32'(err_count), 32'd0);
            chk32("start_clr_first", first_err_addr, 32'd0);
            n = 0; vh = 1;
            while (!done && n < 200) begin
                @(negedge clk);
                n++;
                if (mem_valid) vh++;
            end
            chk32("run_cycles", 32'(n), 32'(sc[s].exp_cycles));
            chk32("valid_high_cycles", 32'(vh), 32'(sc[s].exp_vhigh));
            chk1("end_done", done, 1'b1);
            chk1("end_busy", busy, 1'b0);
            chk1("end_pass", pass, sc[s].exp_pass);
            chk1("end_timeout", timeout, sc[s].exp_to);
            chk32("end_err", 32'(err_count), 32'(sc[s].exp_err));
            chk32("end_first", first_err_addr, sc[s].exp_first);
            chk32("txn_count", 32'(obs_q.size()), 32'(sc[s].exp_txns));
            if (obs_q.size() == sc[s].exp_txns && sc[s].exp_txns == 8) begin
                for (int k = 0; k < 8; k++) begin
                    chk32("txn_addr", obs_q[k].addr, exp_tbl[k].addr);
                    chk32("txn_wstrb", 32'(obs_q[k].wstrb), 32'(exp_tbl[k].wstrb));
                    if (exp_tbl[k].wstrb == 4'hF) chk32("txn_wdata", obs_q[k].wdata, exp_tbl[k].wdata);
                end
            end
            repeat (3) @(negedge clk);
            chk1("status_hold_done", done, 1'b1);
        end

        // A start pulse during the write phase must not disturb the run.
        mode = 0;
        obs_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 6;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk32("busy_start_cycles", 32'(n), 32'd32);
        chk1("busy_start_pass", pass, 1'b1);
        chk32("busy_start_txns", 32'(obs_q.size()), 32'd8);
        if (obs_q.size() == 8) begin
            for (int k = 0; k < 8; k++) chk32("busy_start_addr", obs_q[k].addr, exp_tbl[k].addr);
        end
        repeat (3) @(negedge clk);
        chk1("busy_start_idle", busy, 1'b0);

        // Reset while the second write is outstanding.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk1("second_wr_valid", mem_valid, 1'b1);
        chk32("second_wr_addr", mem_addr, 32'h4);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk1("midrst_valid", mem_valid, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_done", done, 1'b0);
        chk32("midrst_err", 32'(err_count), 32'd0);
        chk32("midrst_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        chk1("midrst_stay_idle", mem_valid, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk1("post_rst_start_busy", busy, 1'b1);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk32("post_rst_cycles", 32'(n), 32'd32);
        chk1("post_rst_pass", pass, 1'b1);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
